uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_tx.sv | 176 +++++++++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters, timing derivation and FSM state encoding.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
  localparam int unsigned BAUDRATE_DEF   = 300_000;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Clocks per baud tick; integer division, so odd ratios round down.
  function automatic int unsigned calc_baud_ticks(input int unsigned clk_freq,
                                                  input int unsigned baudrate,
                                                  input int unsigned oversample);
    return clk_freq / (baudrate * oversample);
  endfunction

  function automatic int unsigned calc_bit_clks(input int unsigned clk_freq,
                                                input int unsigned baudrate,
                                                input int unsigned oversample);
    return calc_baud_ticks(clk_freq, baudrate, oversample) * oversample;
  endfunction

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud prescaler: counts 0..BAUD_TICKS-1 and flags a tick on the wrap cycle; clr_i restarts at 0.
module uart_baud_gen #(
  parameter int unsigned BAUD_TICKS = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_TICKS - 1);

  generate
    if (BAUD_TICKS < 1) begin : g_bad_baud_ticks
      $error("uart_baud_gen: BAUD_TICKS must be at least 1");
    end
  endgenerate

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntMax);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB-first, one stop bit, valid/ready byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BAUDRATE   = BAUDRATE_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int unsigned BAUD_TICKS = calc_baud_ticks(CLK_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int unsigned TickW      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(OVERSAMPLE - 1);

  generate
    if (BAUD_TICKS < 1) begin : g_bad_baud_ticks
      $error("uart_tx: CLK_FREQ/(BAUDRATE*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 1) begin : g_bad_oversample
      $error("uart_tx: OVERSAMPLE must be at least 1");
    end
  endgenerate

  uart_state_e      state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic baud_clr;
  logic baud_tick;
  logic bit_end;

  uart_baud_gen #(
    .BAUD_TICKS(BAUD_TICKS)
  ) u_baud_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (baud_clr),
    .tick_o(baud_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    tick_cnt_d = tick_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    baud_clr   = 1'b0;
    bit_end    = baud_tick && (tick_cnt_q == TickMax);

    if (state_q != StIdle && baud_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid_i && ready_q) begin
          // The start bit is driven on the accepting edge; bit timing restarts from here.
          state_d    = StStart;
          shift_d    = tx_data_i;
          bit_idx_d  = '0;
          tick_cnt_d = '0;
          baud_clr   = 1'b1;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^tx_data_i;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tick_cnt_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tick_cnt_q <= tick_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = ready_q;
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: stimulus pushes expected frames, a line monitor decodes and scores them.
module tb_uart_tx;

  localparam int BitClks = 160;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   frames_seen = 0;
  int   last_done_cyc = -1000;
  logic mon_en = 1'b1;
  exp_t exp_q[$];

  uart_tx u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tx_data_i (tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .tx_o      (tx),
    .tx_busy_o (tx_busy),
    .tx_done_o (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Line monitor: on each start-bit edge pop the expected byte and check every sample of the frame.
  initial begin
    logic        prev;
    exp_t        e;
    logic [10:0] fb;
    int          mism, stat_bad, start_cyc;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && prev && !tx) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit seen at cycle %0d, expected none", cyc);
          prev = tx;
        end else begin
          e = exp_q.pop_front();
          if (e.b2b) check($sformatf("b2b_gap_%02h", e.data), start_cyc - last_done_cyc, 1);
          fb = '1;
          fb[0] = 1'b0;
          fb[8:1] = e.data;
`ifdef UART_TX_PARITY_EN
          fb[9] = ^e.data;
`endif
          stat_bad = 0;
          for (int k = 0; k < NBits; k++) begin
            mism = 0;
            for (int j = 0; j < BitClks; j++) begin
              if (k > 0 || j > 0) @(negedge clk);
              if (tx !== fb[k]) mism++;
              if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) stat_bad++;
            end
            check($sformatf("frame_%02h_bit%0d_bad_samples", e.data, k), mism, 0);
          end
          check($sformatf("frame_%02h_status_bad_samples", e.data), stat_bad, 0);
          @(negedge clk);
          check($sformatf("frame_%02h_tx_done", e.data), int'(tx_done), 1);
          check($sformatf("frame_%02h_ready_after", e.data), int'(tx_ready), 1);
          last_done_cyc = cyc;
          frames_seen++;
          prev = tx;
        end
      end else begin
        prev = tx;
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic b2b, input logic keep, input logic push);
    int n;
    if (push) exp_q.push_back('{data: b, b2b: b2b});
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout_%02h: tx_ready=%b, expected 1", b, tx_ready);
    end
    @(posedge clk);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frames_seen < n && k < 10000) begin
      @(negedge clk);
      k++;
    end
    check("frames_completed", frames_seen, n);
  endtask

  initial begin
    int dones, lows;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_ready", int'(tx_ready), 1);
    check("reset_busy", int'(tx_busy), 0);
    check("reset_done", int'(tx_done), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame.
    send(8'h23, 1'b0, 1'b0, 1'b1);
    wait_frames(1);

    // Back-to-back with tx_valid held.
    @(negedge clk);
    send(8'hA5, 1'b0, 1'b1, 1'b1);
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    wait_frames(3);

    // New data offered mid-frame must wait for tx_ready.
    @(negedge clk);
    send(8'h55, 1'b0, 1'b0, 1'b1);
    repeat (300) @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("ready_low_mid_frame", int'(tx_ready), 0);
    check("busy_mid_frame", int'(tx_busy), 1);
    send(8'hFF, 1'b1, 1'b0, 1'b1);
    wait_frames(5);

    // Reset during data bit 3 of 0xAA.
    @(negedge clk);
    mon_en = 1'b0;
    send(8'hAA, 1'b0, 1'b0, 1'b0);
    repeat (700) @(posedge clk);
    #3;
    check("busy_before_reset", int'(tx_busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", int'(tx), 1);
    check("async_reset_ready", int'(tx_ready), 1);
    check("async_reset_busy", int'(tx_busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    lows  = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_done) dones++;
      if (!tx) lows++;
    end
    check("no_done_after_abort", dones, 0);
    check("line_idle_after_abort", lows, 0);
    mon_en = 1'b1;
    send(8'h0F, 1'b0, 1'b0, 1'b1);
    wait_frames(6);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
